// File: rtl/cr16_control_fsm_if.sv
// Bus bundle between the CR16 control FSM and its instruction memory,
// register file and ALU.
//   master : the control FSM (drives fetch, register addresses, ALU operands,
//            writeback, PSR, illegal_op and state)
//   slave  : the surrounding datapath and memory (drives run, instruction
//            data, register read data, ALU result and flags)
interface cr16_control_fsm_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              run;
  logic              instr_req;
  logic [ADDR_W-1:0] instr_addr;
  logic              instr_valid;
  logic [15:0]       instr_data;
  logic [3:0]        rf_ra_addr;
  logic [3:0]        rf_rb_addr;
  logic [15:0]       rf_ra_data;
  logic [15:0]       rf_rb_data;
  logic [15:0]       alu_a;
  logic [15:0]       alu_b;
  logic [7:0]        alu_opcode;
  logic              alu_carry_in;
  logic [15:0]       alu_result;
  logic [4:0]        alu_flags;
  logic              rf_we;
  logic [3:0]        rf_wr_addr;
  logic [15:0]       rf_wr_data;
  logic [4:0]        psr;
  logic              illegal_op;
  logic [2:0]        state;

  modport master (
    input  run, instr_valid, instr_data, rf_ra_data, rf_rb_data, alu_result, alu_flags,
    output instr_req, instr_addr, rf_ra_addr, rf_rb_addr, alu_a, alu_b, alu_opcode,
           alu_carry_in, rf_we, rf_wr_addr, rf_wr_data, psr, illegal_op, state
  );

  modport slave (
    output run, instr_valid, instr_data, rf_ra_data, rf_rb_data, alu_result, alu_flags,
    input  instr_req, instr_addr, rf_ra_addr, rf_rb_addr, alu_a, alu_b, alu_opcode,
           alu_carry_in, rf_we, rf_wr_addr, rf_wr_data, psr, illegal_op, state
  );
endinterface

// File: rtl/cr16_control_fsm.sv
// CR16 fetch/decode/execute/writeback controller feeding a 16-bit ALU.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : cr16_control_fsm_if.master (fetch, register file, ALU, PSR, status)
// Every output is a flop or a bit-slice of one (IR, PC, PSR, result).
module cr16_control_fsm #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  cr16_control_fsm_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [15:0]       ir_q;
  logic [15:0]       alu_a_q;
  logic [15:0]       alu_b_q;
  logic [7:0]        alu_opcode_q;
  logic [15:0]       result_q;
  logic [4:0]        psr_q;
  logic              instr_req_q;
  logic              rf_we_q;
  logic              illegal_q;

  logic [3:0]  hi;
  logic [3:0]  ext;
  logic        dec_illegal;
  logic        dec_sets_flags;
  logic        dec_writes;
  logic [7:0]  dec_opcode;
  logic [15:0] dec_b;

  assign hi  = ir_q[15:12];
  assign ext = ir_q[7:4];

  // Instruction decode from IR; IR is stable from DECODE through WRITEBACK.
  always_comb begin
    dec_illegal    = 1'b0;
    dec_sets_flags = 1'b0;
    dec_writes     = 1'b1;
    dec_opcode     = {hi, ext};
    dec_b          = bus.rf_rb_data;
    case (hi)
      4'h0: begin
        dec_illegal    = ext inside {4'hA, 4'hD, 4'hE};
        dec_sets_flags = ext inside {4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hB, 4'hC};
        // Compares and NOP produce no register result.
        dec_writes     = !(ext inside {4'h0, 4'h8, 4'hB, 4'hC});
      end
      4'h8: begin
        dec_illegal = !((ext[3:1] == 3'b000) || (ext[3:2] == 2'b01));
        // Immediate shift count lives in the Rsrc field.
        if (ext[3:1] == 3'b000) dec_b = {12'b0, ir_q[3:0]};
      end
      4'h5, 4'h7, 4'h9, 4'hB: begin
        dec_opcode     = {hi, 4'h0};
        dec_b          = {{8{ir_q[7]}}, ir_q[7:0]};
        dec_sets_flags = 1'b1;
        dec_writes     = (hi != 4'hB);
      end
      4'h4, 4'h6: begin
        dec_opcode     = {hi, 4'h0};
        dec_b          = {8'h00, ir_q[7:0]};
        dec_sets_flags = 1'b1;
      end
      default: begin
        dec_illegal = 1'b1;
        dec_writes  = 1'b0;
      end
    endcase
  end

  // Controller state machine with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= '0;
      result_q     <= '0;
      psr_q        <= '0;
      instr_req_q  <= 1'b0;
      rf_we_q      <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      rf_we_q   <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.run) begin
            state_q     <= S_FETCH;
            instr_req_q <= 1'b1;
          end
        end
        S_FETCH: begin
          if (bus.instr_valid) begin
            ir_q        <= bus.instr_data;
            pc_q        <= pc_q + ADDR_W'(1);
            instr_req_q <= 1'b0;
            state_q     <= S_DECODE;
          end
        end
        S_DECODE: begin
          alu_a_q      <= bus.rf_ra_data;
          alu_b_q      <= dec_b;
          alu_opcode_q <= dec_opcode;
          illegal_q    <= dec_illegal;
          state_q      <= S_EXECUTE;
        end
        S_EXECUTE: begin
          result_q <= bus.alu_result;
          if (dec_sets_flags && !dec_illegal) psr_q <= bus.alu_flags;
          rf_we_q  <= dec_writes && !dec_illegal;
          state_q  <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          if (bus.run) begin
            state_q     <= S_FETCH;
            instr_req_q <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          instr_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.instr_req    = instr_req_q;
  assign bus.instr_addr   = pc_q;
  assign bus.rf_ra_addr   = ir_q[11:8];
  assign bus.rf_rb_addr   = ir_q[3:0];
  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.alu_opcode   = alu_opcode_q;
  assign bus.alu_carry_in = psr_q[3];
  assign bus.rf_we        = rf_we_q;
  assign bus.rf_wr_addr   = ir_q[11:8];
  assign bus.rf_wr_data   = result_q;
  assign bus.psr          = psr_q;
  assign bus.illegal_op   = illegal_q;
  assign bus.state        = state_q;

endmodule

// File: doc/cr16_control_fsm.md
Name: cr16_control_fsm

Overview:
- Multi-cycle fetch/decode/execute/writeback controller sitting directly upstream of the 16-bit ALU.
- Fetches 16-bit instructions from instruction memory and reads operands from the register file.
- Drives the ALU's A, B, Opcode and carryIn, captures the ALU's C and Flags, and writes results back.
- Holds the processor status register (PSR) that feeds carry back to the ALU.

Parameters:
ADDR_W, 16, instruction address / PC width
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
run  in  1  enables execution; sampled in IDLE and at end of WRITEBACK
instr_req  out  1  instruction fetch request
instr_addr  out  ADDR_W  fetch address (PC)
instr_valid  in  1  instr_data valid this cycle
instr_data  in  16  fetched instruction
rf_ra_addr  out  4  register file read port A address = IR[11:8]
rf_rb_addr  out  4  register file read port B address = IR[3:0]
rf_ra_data  in  16  port A data, combinational read
rf_rb_data  in  16  port B data, combinational read
alu_a  out  16  ALU A operand
alu_b  out  16  ALU B operand
alu_opcode  out  8  ALU Opcode
alu_carry_in  out  1  ALU carryIn = psr[3]
alu_result  in  16  ALU C
alu_flags  in  5  ALU Flags {Z,C,O,L,N}
rf_we  out  1  register write enable (1-cycle pulse)
rf_wr_addr  out  4  write address
rf_wr_data  out  16  write data
psr  out  5  status register {Z,C,O,L,N}
illegal_op  out  1  1-cycle pulse on undecodable instruction
state  out  3  IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4

Behaviour:
- Reset (async, any state):
  - state=IDLE, PC=RESET_PC, IR=0, psr=0, result register=0.
  - All outputs 0 except instr_addr=RESET_PC.
  - Any in-flight instruction is abandoned: no rf_we, no PSR update.
- IDLE: go to FETCH when run=1.
- FETCH:
  - instr_req=1; instr_addr=PC, held stable until instr_valid.
  - On instr_valid: IR<=instr_data, PC<=PC+1 (wraps modulo 2^ADDR_W), go to DECODE.
  - Without instr_valid: stay in FETCH with no timeout. instr_valid outside FETCH is ignored.
- DECODE:
  - One cycle; rf_ra_addr and rf_rb_addr are driven from IR.
  - Operand B select:
    - hi=IR[15:12], ext=IR[7:4].
    - hi=0000: register format; alu_opcode={hi,ext}; B=rf_rb_data.
    - hi=1000: shift format; alu_opcode={hi,ext}. ext=000x gives B={12'b0,IR[3:0]}; otherwise B=rf_rb_data.
    - hi in {0101,0111,1001,1011}: alu_opcode={hi,4'b0}; B=sign-extended IR[7:0].
    - hi in {0100,0110}: alu_opcode={hi,4'b0}; B=zero-extended IR[7:0].
  - A=rf_ra_data in all formats.
  - A, B and alu_opcode are registered at the end of DECODE.
- EXECUTE:
  - One cycle; ALU inputs are stable; alu_carry_in=psr[3].
  - result register <= alu_result.
  - PSR <= alu_flags only for flag-setting ops:
    - register ext in {0100,0101,0110,0111,1000,1001,1011,1100};
    - all immediate hi values listed above.
  - Logic ops, shifts and NOT leave PSR unchanged.
- WRITEBACK:
  - rf_we=1 for one cycle; rf_wr_addr=IR[11:8]; rf_wr_data=result.
  - No writeback for compares (register ext 1000/1011/1100, immediate hi 1011) or NOP (hi=0000, ext=0000).
  - Next state: FETCH if run=1, else IDLE.
- Illegal encodings:
  - Any of: hi in {0001,0010,0011,1010,1100–1111}; hi=0000 with ext in {1010,1101,1110}; hi=1000 with ext not in {000x,01xx}.
  - Handling: illegal_op pulses in EXECUTE; no PSR update; no writeback; PC advances normally.
- Throughput: 4 cycles per instruction with zero-wait memory. rf_we asserts 3 cycles after the instr_valid cycle.

Test Plan:
- Reset: assert reset mid-sequence -> state=0, psr=0, rf_we=0, instr_req=0, instr_addr=0 immediately; after release with run=1, FETCH at PC=0.
- ADD R1,R2 (0x0152), ra_data=5, rb_data=7, model ALU -> in EXECUTE alu_opcode=0x05, alu_a=5, alu_b=7; WRITEBACK rf_we=1, rf_wr_addr=1, rf_wr_data=12.
- ADDI R3,#-2 (0x53FE) -> alu_opcode=0x50, alu_b=0xFFFE. ADDUI R3,#0xFE (0x63FE) -> alu_b=0x00FE. LSHI R3,#5 (0x8305) -> alu_opcode=0x80, alu_b=0x0005.
- CMP R1,R2 (0x01B2), alu_flags=5'b00011 -> psr=5'b00011 after EXECUTE; rf_we stays 0. Following AND (0x0112) leaves psr=5'b00011.
- Carry chain: after an ADD yielding psr[3]=1, ADDC (0x0172) -> alu_carry_in=1 during EXECUTE.
- Wait states: instr_valid delayed 3 cycles -> instr_req held 4 cycles, instr_addr stable. Illegal 0xC000 -> illegal_op pulse, no rf_we, psr unchanged, PC incremented. Reset in EXECUTE -> rf_we never asserted.
